// File: rtl/tiled_matmul_seq.sv
// Tiled matrix-multiply sequencer: one MAC walks a tile-ordered loop nest over
// row-major A, B and C held in external synchronous RAMs, optionally accumulating
// into the existing C, saturating each result to DATA_W on write-back.
module tiled_matmul_seq #(
    parameter int DATA_W = 16,
    parameter int M      = 4,
    parameter int P      = 4,
    parameter int N      = 4,
    parameter int TILE   = 2,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              accumulate,
    output logic              busy,
    output logic              done,
    output logic              sat_flag,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_rd_addr,
    input  logic [DATA_W-1:0] a_rd_data,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] b_rd_addr,
    input  logic [DATA_W-1:0] b_rd_data,
    output logic              c_rd_en,
    output logic [ADDR_W-1:0] c_rd_addr,
    input  logic [DATA_W-1:0] c_rd_data,
    output logic              c_wr_en,
    output logic [ADDR_W-1:0] c_wr_addr,
    output logic [DATA_W-1:0] c_wr_data
);

    localparam int ACC_W = 2 * DATA_W + $clog2(P) + 1;

    localparam logic [ADDR_W-1:0] M_A = ADDR_W'(M);
    localparam logic [ADDR_W-1:0] N_A = ADDR_W'(N);
    localparam logic [ADDR_W-1:0] P_A = ADDR_W'(P);
    localparam logic [ADDR_W-1:0] T_A = ADDR_W'(TILE);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_C,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] i0_q, i0_d, l0_q, l0_d;
    logic [ADDR_W-1:0] ii_q, ii_d, ll_q, ll_d;
    logic [ADDR_W-1:0] r_q, r_d;
    logic              acc_mode_q, acc_mode_d;
    logic              sat_q, sat_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    logic [ADDR_W-1:0]         row, col, tile_m, tile_n;
    logic signed [2*DATA_W-1:0] a_ext, b_ext, prod;
    logic signed [ACC_W-1:0]   prod_ext, c_ext;
    logic                      clamp_hi, clamp_lo;
    logic [DATA_W-1:0]         wr_val;

    // Datapath: element coordinates, clipped tile extents, product and saturation
    always_comb begin
        row      = i0_q + ii_q;
        col      = l0_q + ll_q;
        tile_m   = ((M_A - i0_q) < T_A) ? (M_A - i0_q) : T_A;
        tile_n   = ((N_A - l0_q) < T_A) ? (N_A - l0_q) : T_A;
        a_ext    = {{DATA_W{a_rd_data[DATA_W-1]}}, a_rd_data};
        b_ext    = {{DATA_W{b_rd_data[DATA_W-1]}}, b_rd_data};
        prod     = a_ext * b_ext;
        prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        c_ext    = {{(ACC_W-DATA_W){c_rd_data[DATA_W-1]}}, c_rd_data};
        clamp_hi = acc_q > SAT_MAX;
        clamp_lo = acc_q < SAT_MIN;
        if (clamp_hi) begin
            wr_val = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (clamp_lo) begin
            wr_val = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            wr_val = acc_q[DATA_W-1:0];
        end
    end

    // Port outputs decoded from the registered state
    always_comb begin
        busy      = (state_q != S_IDLE) && (state_q != S_DONE);
        done      = (state_q == S_DONE);
        sat_flag  = sat_q;
        a_rd_en   = (state_q == S_MAC);
        b_rd_en   = (state_q == S_MAC);
        c_rd_en   = (state_q == S_LOAD_C);
        c_wr_en   = (state_q == S_WRITE);
        a_rd_addr = row * P_A + r_q;
        b_rd_addr = r_q * N_A + col;
        c_rd_addr = row * N_A + col;
        c_wr_addr = row * N_A + col;
        c_wr_data = wr_val;
    end

    // Next-state logic: loop nest i0 > l0 > ii > ll > r, advanced on each write
    always_comb begin
        state_d    = state_q;
        i0_d       = i0_q;
        l0_d       = l0_q;
        ii_d       = ii_q;
        ll_d       = ll_q;
        r_d        = r_q;
        acc_mode_d = acc_mode_q;
        sat_d      = sat_q;
        acc_d      = acc_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_mode_d = accumulate;
                    sat_d      = 1'b0;
                    i0_d       = '0;
                    l0_d       = '0;
                    ii_d       = '0;
                    ll_d       = '0;
                    r_d        = '0;
                    acc_d      = '0;
                    state_d    = accumulate ? S_LOAD_C : S_MAC;
                end
            end
            S_LOAD_C: begin
                state_d = S_MAC;
            end
            S_MAC: begin
                // Products land one cycle after their request, so r=0 only seeds the accumulator
                if (r_q == '0) begin
                    acc_d = acc_mode_q ? c_ext : '0;
                end else begin
                    acc_d = acc_q + prod_ext;
                end
                if (r_q == P_A - ONE) begin
                    r_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    r_d = r_q + ONE;
                end
            end
            S_DRAIN: begin
                acc_d   = acc_q + prod_ext;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                sat_d   = sat_q | clamp_hi | clamp_lo;
                state_d = acc_mode_q ? S_LOAD_C : S_MAC;
                if (ll_q + ONE < tile_n) begin
                    ll_d = ll_q + ONE;
                end else begin
                    ll_d = '0;
                    if (ii_q + ONE < tile_m) begin
                        ii_d = ii_q + ONE;
                    end else begin
                        ii_d = '0;
                        if (l0_q + T_A < N_A) begin
                            l0_d = l0_q + T_A;
                        end else begin
                            l0_d = '0;
                            if (i0_q + T_A < M_A) begin
                                i0_d = i0_q + T_A;
                            end else begin
                                i0_d    = '0;
                                state_d = S_DONE;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            i0_q       <= '0;
            l0_q       <= '0;
            ii_q       <= '0;
            ll_q       <= '0;
            r_q        <= '0;
            acc_mode_q <= 1'b0;
            sat_q      <= 1'b0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            i0_q       <= i0_d;
            l0_q       <= l0_d;
            ii_q       <= ii_d;
            ll_q       <= ll_d;
            r_q        <= r_d;
            acc_mode_q <= acc_mode_d;
            sat_q      <= sat_d;
            acc_q      <= acc_d;
        end
    end

endmodule

// File: tb/tb_tiled_matmul_seq.sv
// Testbench for tiled_matmul_seq: two instances (2x2x2 8-bit, TILE=1 and
// 3x1x3 16-bit, TILE=2) backed by synchronous RAM models; C writes are
// checked against a scoreboard filled when each job is launched.
module tb_tiled_matmul_seq;

    localparam int AW  = 10;
    localparam int DW1 = 8;
    localparam int M1  = 2;
    localparam int P1  = 2;
    localparam int N1  = 2;
    localparam int T1  = 1;
    localparam int DW2 = 16;
    localparam int M2  = 3;
    localparam int P2  = 1;
    localparam int N2  = 3;
    localparam int T2  = 2;

    typedef struct {
        logic [AW-1:0] addr;
        int            data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance 1 signals and memories
    logic start1 = 1'b0, acc1 = 1'b0;
    logic busy1, done1, sat1;
    logic a_en1, b_en1, c_ren1, c_we1;
    logic [AW-1:0] a_addr1, b_addr1, c_raddr1, c_waddr1;
    logic [DW1-1:0] a_d1 = '0, b_d1 = '0, c_d1 = '0, c_wd1;
    logic signed [DW1-1:0] amem1 [0:(1<<AW)-1];
    logic signed [DW1-1:0] bmem1 [0:(1<<AW)-1];
    logic signed [DW1-1:0] cmem1 [0:(1<<AW)-1];
    wr_t q1[$];
    int  rdcnt1 = 0, wrcnt1 = 0;

    // Instance 2 signals and memories
    logic start2 = 1'b0, acc2 = 1'b0;
    logic busy2, done2, sat2;
    logic a_en2, b_en2, c_ren2, c_we2;
    logic [AW-1:0] a_addr2, b_addr2, c_raddr2, c_waddr2;
    logic [DW2-1:0] a_d2 = '0, b_d2 = '0, c_d2 = '0, c_wd2;
    logic signed [DW2-1:0] amem2 [0:(1<<AW)-1];
    logic signed [DW2-1:0] bmem2 [0:(1<<AW)-1];
    logic signed [DW2-1:0] cmem2 [0:(1<<AW)-1];
    wr_t q2[$];
    int  wrcnt2 = 0;

    tiled_matmul_seq #(.DATA_W(DW1), .M(M1), .P(P1), .N(N1), .TILE(T1), .ADDR_W(AW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .accumulate(acc1),
        .busy(busy1), .done(done1), .sat_flag(sat1),
        .a_rd_en(a_en1), .a_rd_addr(a_addr1), .a_rd_data(a_d1),
        .b_rd_en(b_en1), .b_rd_addr(b_addr1), .b_rd_data(b_d1),
        .c_rd_en(c_ren1), .c_rd_addr(c_raddr1), .c_rd_data(c_d1),
        .c_wr_en(c_we1), .c_wr_addr(c_waddr1), .c_wr_data(c_wd1)
    );

    tiled_matmul_seq #(.DATA_W(DW2), .M(M2), .P(P2), .N(N2), .TILE(T2), .ADDR_W(AW)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .accumulate(acc2),
        .busy(busy2), .done(done2), .sat_flag(sat2),
        .a_rd_en(a_en2), .a_rd_addr(a_addr2), .a_rd_data(a_d2),
        .b_rd_en(b_en2), .b_rd_addr(b_addr2), .b_rd_data(b_d2),
        .c_rd_en(c_ren2), .c_rd_addr(c_raddr2), .c_rd_data(c_d2),
        .c_wr_en(c_we2), .c_wr_addr(c_waddr2), .c_wr_data(c_wd2)
    );

    // Synchronous RAM models
    always @(posedge clk) begin
        if (a_en1) a_d1 <= amem1[a_addr1];
        if (b_en1) b_d1 <= bmem1[b_addr1];
        if (c_ren1) c_d1 <= cmem1[c_raddr1];
        if (c_we1) cmem1[c_waddr1] <= c_wd1;
        if (a_en2) a_d2 <= amem2[a_addr2];
        if (b_en2) b_d2 <= bmem2[b_addr2];
        if (c_ren2) c_d2 <= cmem2[c_raddr2];
        if (c_we2) cmem2[c_waddr2] <= c_wd2;
    end

    // Scoreboard monitor for instance 1
    wr_t            e1;
    logic [DW1-1:0] ev1;
    always @(negedge clk) begin
        if (c_ren1 === 1'b1) rdcnt1++;
        if (c_we1 === 1'b1) begin
            wrcnt1++;
            n_tests++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL c_write1: unexpected write addr %0d data %0d, required no write", c_waddr1, $signed(c_wd1));
            end else begin
                e1  = q1.pop_front();
                ev1 = e1.data[DW1-1:0];
                if (c_waddr1 !== e1.addr || c_wd1 !== ev1) begin
                    n_fail++;
                    $display("FAIL c_write1: got addr %0d data %0d, required addr %0d data %0d",
                             c_waddr1, $signed(c_wd1), e1.addr, e1.data);
                end
            end
        end
    end

    // Scoreboard monitor for instance 2
    wr_t            e2;
    logic [DW2-1:0] ev2;
    always @(negedge clk) begin
        if (c_we2 === 1'b1) begin
            wrcnt2++;
            n_tests++;
            if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL c_write2: unexpected write addr %0d data %0d, required no write", c_waddr2, $signed(c_wd2));
            end else begin
                e2  = q2.pop_front();
                ev2 = e2.data[DW2-1:0];
                if (c_waddr2 !== e2.addr || c_wd2 !== ev2) begin
                    n_fail++;
                    $display("FAIL c_write2: got addr %0d data %0d, required addr %0d data %0d",
                             c_waddr2, $signed(c_wd2), e2.addr, e2.data);
                end
            end
        end
    end

    // Reference model for instance 1: tile-ordered, saturating
    task automatic expect1(input bit acc);
        int  lo, hi, s, i, l;
        wr_t w;
        lo = -(1 << (DW1 - 1));
        hi = (1 << (DW1 - 1)) - 1;
        for (int i0 = 0; i0 < M1; i0 += T1)
            for (int l0 = 0; l0 < N1; l0 += T1)
                for (int ii = 0; ii < T1 && i0 + ii < M1; ii++)
                    for (int ll = 0; ll < T1 && l0 + ll < N1; ll++) begin
                        i = i0 + ii;
                        l = l0 + ll;
                        s = acc ? int'(cmem1[i*N1+l]) : 0;
                        for (int r = 0; r < P1; r++)
                            s += int'(amem1[i*P1+r]) * int'(bmem1[r*N1+l]);
                        if (s > hi) s = hi;
                        if (s < lo) s = lo;
                        w.addr = AW'(i * N1 + l);
                        w.data = s;
                        q1.push_back(w);
                    end
    endtask

    task automatic fill1(input int a0, input int a1, input int a2, input int a3,
                         input int b0, input int b1, input int b2, input int b3);
        amem1[0] = DW1'(a0); amem1[1] = DW1'(a1); amem1[2] = DW1'(a2); amem1[3] = DW1'(a3);
        bmem1[0] = DW1'(b0); bmem1[1] = DW1'(b1); bmem1[2] = DW1'(b2); bmem1[3] = DW1'(b3);
    endtask

    task automatic check_c1(input string name, input int c0, input int c1v, input int c2, input int c3);
        n_tests++;
        if (int'(cmem1[0]) !== c0 || int'(cmem1[1]) !== c1v || int'(cmem1[2]) !== c2 || int'(cmem1[3]) !== c3) begin
            n_fail++;
            $display("FAIL %s: got C=[%0d %0d %0d %0d], required [%0d %0d %0d %0d]", name,
                     cmem1[0], cmem1[1], cmem1[2], cmem1[3], c0, c1v, c2, c3);
        end
    endtask

    // Launch one job on instance 1 and follow it to done
    task automatic run_job1(input string name, input bit acc, input bit glitch, input bit exp_sat);
        int k, exp_done;
        bit seen;
        exp_done = M1 * N1 * (P1 + 2 + (acc ? 1 : 0)) + 1;
        @(negedge clk);
        expect1(acc);
        rdcnt1 = 0;
        wrcnt1 = 0;
        acc1   = acc;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        acc1   = ~acc;
        seen   = 1'b0;
        for (k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_tests++;
                if (busy1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s busy_cycle1: got %b, required 1", name, busy1);
                end
            end
            if (done1 === 1'b1) begin
                seen = 1'b1;
                break;
            end
            start1 = glitch && (k == 3 || k == 5);
        end
        start1 = 1'b0;
        acc1   = 1'b0;
        n_tests++;
        if (!seen || k != exp_done) begin
            n_fail++;
            $display("FAIL %s done_cycle: got %0d (seen=%0d), required %0d", name, k, seen, exp_done);
        end
        n_tests++;
        if (busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_in_done: got %b, required 0", name, busy1);
        end
        n_tests++;
        if (sat1 !== exp_sat) begin
            n_fail++;
            $display("FAIL %s sat_flag: got %b, required %b", name, sat1, exp_sat);
        end
        n_tests++;
        if (wrcnt1 != M1 * N1 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d writes (%0d pending), required %0d", name, wrcnt1, q1.size(), M1 * N1);
        end
        n_tests++;
        if (rdcnt1 != (acc ? M1 * N1 : 0)) begin
            n_fail++;
            $display("FAIL %s c_rd_pulses: got %0d, required %0d", name, rdcnt1, acc ? M1 * N1 : 0);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy1, done1, sat1, a_en1, b_en1, c_ren1, c_we1} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 0000000", {busy1, done1, sat1, a_en1, b_en1, c_ren1, c_we1});
        end
        n_tests++;
        if ((a_addr1 | b_addr1 | c_raddr1 | c_waddr1) !== '0 || c_wd1 !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: got a=%0d b=%0d cr=%0d cw=%0d wd=%0d, required all 0",
                     a_addr1, b_addr1, c_raddr1, c_waddr1, c_wd1);
        end
        n_tests++;
        if ({busy2, done2, sat2, c_we2} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_dut2: got %b, required 0000", {busy2, done2, sat2, c_we2});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        fill1(1, 2, 3, 4, 5, 6, 7, 8);
        run_job1("basic", 1'b0, 1'b0, 1'b0);
        check_c1("basic_c", 19, 22, 43, 50);
    endtask

    task automatic test_accumulate;
        for (int i = 0; i < 4; i++) cmem1[i] = 8'sd1;
        run_job1("accum", 1'b1, 1'b0, 1'b0);
        check_c1("accum_c", 20, 23, 44, 51);
    endtask

    task automatic test_saturation;
        fill1(127, 127, 127, 127, 127, 127, 127, 127);
        run_job1("sat_pos", 1'b0, 1'b0, 1'b1);
        check_c1("sat_pos_c", 127, 127, 127, 127);
        fill1(-128, -128, -128, -128, 127, 127, 127, 127);
        run_job1("sat_neg", 1'b0, 1'b0, 1'b1);
        check_c1("sat_neg_c", -128, -128, -128, -128);
        fill1(1, 1, 1, 1, 1, 1, 1, 1);
        run_job1("sat_clear", 1'b0, 1'b0, 1'b0);
        check_c1("sat_clear_c", 2, 2, 2, 2);
    endtask

    task automatic test_start_ignored;
        fill1(1, 2, 3, 4, 5, 6, 7, 8);
        for (int i = 0; i < 4; i++) cmem1[i] = 8'sd0;
        run_job1("restart", 1'b0, 1'b1, 1'b0);
        check_c1("restart_c", 19, 22, 43, 50);
    endtask

    task automatic test_reset_abort;
        fill1(1, 2, 3, 4, 5, 6, 7, 8);
        for (int i = 0; i < 4; i++) cmem1[i] = 8'sd0;
        @(negedge clk);
        expect1(1'b0);
        acc1   = 1'b0;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy1, done1, a_en1, b_en1, c_ren1, c_we1} !== 6'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: got %b, required 000000", {busy1, done1, a_en1, b_en1, c_ren1, c_we1});
        end
        q1.delete();
        wrcnt1 = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        n_tests++;
        if (wrcnt1 != 0 || done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiet: got %0d writes done=%b, required 0 writes done=0", wrcnt1, done1);
        end
        run_job1("after_abort", 1'b0, 1'b0, 1'b0);
        check_c1("after_abort_c", 19, 22, 43, 50);
    endtask

    task automatic test_tile_order;
        int  order [9] = '{0, 1, 3, 4, 2, 5, 6, 7, 8};
        int  k;
        bit  seen;
        wr_t w;
        for (int i = 0; i < 3; i++) begin
            amem2[i] = 16'sd1;
            bmem2[i] = 16'sd1;
        end
        for (int i = 0; i < 9; i++) cmem2[i] = 16'sd0;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            w.addr = AW'(order[i]);
            w.data = 1;
            q2.push_back(w);
        end
        wrcnt2 = 0;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        seen   = 1'b0;
        for (k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (done2 === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!seen || k != 9 * 3 + 1) begin
            n_fail++;
            $display("FAIL tile_done_cycle: got %0d (seen=%0d), required %0d", k, seen, 9 * 3 + 1);
        end
        n_tests++;
        if (wrcnt2 != 9 || q2.size() != 0) begin
            n_fail++;
            $display("FAIL tile_write_count: got %0d (%0d pending), required 9", wrcnt2, q2.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_accumulate();
        test_saturation();
        test_start_ignored();
        test_reset_abort();
        test_tile_order();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
